down_counter_unit: RTL and testbench
====================================

// Module: down_counter_unit
// PURPOSE
//  8-bit synchronous down counter/timer built from two cascaded 4-bit down stages.
//  Borrow ripples stage 1 -> stage 2 on the trickle enable.
//  Counterpart to the existing up-counting units: it counts a loaded value down to zero.
//  Flags terminal count and optionally auto-reloads, for interval and timeout generation.
// PARAMETERS
//  STAGE_W   4   width of one down stage (bits)
//  STAGES    2   number of cascaded stages; total width N = STAGE_W*STAGES = 8
// PORTS
//  CP         in   1  clock, all state changes on rising edge
//  SR         in   1  synchronous reset, active-high
//  P          in   N  parallel load value
//  PE         in   1  parallel load enable, active-high
//  CEP        in   1  count enable parallel
//  CET        in   1  count enable trickle (cascade input)
//  RELOAD_EN  in   1  1: reload from RLD at zero; 0: wrap to all-ones
//  Q          out  N  counter value
//  TC         out  1  terminal count, combinational: CET & (Q == 0)
//  DONE       out  1  registered one-cycle pulse after a counted zero event
//  RLD        out  N  stored reload value (last P captured by PE)
// BEHAVIOUR
//  - Reset (SR=1 at edge): Q=0, RLD=0, DONE=0. TC then follows CET.
//  - Priority at each edge: SR > PE > count > hold.
//  - PE=1: Q<=P and RLD<=P. DONE<=0. CEP/CET are ignored on that edge.
//  - Count when CEP & CET & !PE:
//      - If Q != 0: Q <= Q-1, modulo 2^N. Borrow is internal, via the stage cascade.
//      - If Q == 0: "zero event". Q <= RLD if RELOAD_EN=1, else Q <= {N{1'b1}}. DONE<=1.
//  - DONE=0 on every edge without a zero event. It is exactly one cycle wide per event.
//  - Hold: CEP=0 or CET=0 leaves Q and RLD unchanged.
//  - TC has no dependency on CEP, so stages and units can chain TC -> CET.
//  - Stage k>0 trickle enable is CET & TC of stage k-1.
//      - Stage k decrements only when every lower stage is zero.
//  - Load P=0: TC asserts in the same cycle the load completes, if CET=1.
//    The next counted edge is a zero event.
//  - RELOAD_EN=1 with RLD=0: Q stays 0. DONE pulses on every counted edge.
//  - RELOAD_EN is sampled only at a zero event. Changing it mid-count is legal.
//  - SR mid-count: takes effect next edge. No partial count or DONE.
//  - Latency: load and decrement are visible 1 cycle after the edge. TC is 0-cycle (combinational).
// STRUCTURE
//  - Shared package: N_W = STAGE_W*STAGES; constant ALL_ONES; constant ZERO.
//  - Sub-module down_counter_stage, instantiated STAGES times:
//      - Ports: CP, SR, P[STAGE_W-1:0], PE, CEP, CET, LD_ZERO, LD_VAL,
//        Q[STAGE_W-1:0], TC.
//      - LD_ZERO/LD_VAL are driven by the top to force the reload value or ALL_ONES.
//  - Top-level logic: RLD register, zero-event detect (CEP & CET & !PE & Q==0),
//    DONE register, stage cascade.
// TESTING
//  1. SR=1, one edge -> Q=0x00, RLD=0x00, DONE=0. With CET=1, TC=1.
//  2. PE=1, P=0x12; then CEP=CET=1 for 0x12 edges -> Q steps 0x11, 0x10, 0x0F, ..., 0x00.
//     Stage 2 decrements exactly at 0x10 -> 0x0F.
//  3. Q=0x00, RELOAD_EN=1, RLD=0x05, one counted edge -> Q=0x05, DONE=1 for one cycle.
//     The next counted edge -> Q=0x04, DONE=0.
//  4. Q=0x00, RELOAD_EN=0, one counted edge -> Q=0xFF, DONE=1.
//  5. Q=0x30, PE=1, P=0x07 with CEP=CET=1 on the same edge -> Q=0x07 (load wins).
//     CET=0 with CEP=1 -> Q holds 0x07, TC=0.
//  6. Q=0x00, CEP=CET=1, SR=1 and RELOAD_EN=1 on the same edge -> Q=0x00, DONE=0 (reset wins).

Source files
------------

// File: rtl/down_counter_unit_pkg.sv
// Shared widths and constants for the cascaded down counter unit.
// Imported by the top and the stage sub-module.
package down_counter_unit_pkg;

    localparam int STAGE_W = 4;
    localparam int STAGES  = 2;
    localparam int N_W     = STAGE_W * STAGES;

    localparam logic [N_W-1:0] ALL_ONES = '1;
    localparam logic [N_W-1:0] ZERO     = '0;

endpackage

// File: rtl/down_counter_stage.sv
// One cascadable down-counting stage: load, forced zero-event load, decrement, hold.
// TC is combinational and independent of CEP so stages chain TC -> CET.
module down_counter_stage
    import down_counter_unit_pkg::*;
#(
    parameter int STAGE_W = down_counter_unit_pkg::STAGE_W
) (
    input  logic               CP,
    input  logic               SR,
    input  logic [STAGE_W-1:0] P,
    input  logic               PE,
    input  logic               CEP,
    input  logic               CET,
    input  logic               LD_ZERO,
    input  logic [STAGE_W-1:0] LD_VAL,
    output logic [STAGE_W-1:0] Q,
    output logic               TC
);

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the pre-edge values of its neighbours, exactly like the real cascade.
    always_ff @(posedge CP) begin
        if (SR) begin
            Q <= '0;
        end else if (PE) begin
            Q <= P;
        end else if (LD_ZERO) begin
            Q <= LD_VAL;
        end else if (CEP && CET) begin
            Q <= Q - STAGE_W'(1);
        end
    end

    assign TC = CET && (Q == '0);

endmodule

// File: rtl/down_counter_unit.sv
// 8-bit down counter/timer from cascaded stages, with terminal count,
// optional auto-reload from the last loaded value, and a one-cycle DONE pulse.
module down_counter_unit
    import down_counter_unit_pkg::*;
#(
    parameter int STAGE_W = down_counter_unit_pkg::STAGE_W,
    parameter int STAGES  = down_counter_unit_pkg::STAGES
) (
    input  logic                       CP,
    input  logic                       SR,
    input  logic [STAGE_W*STAGES-1:0]  P,
    input  logic                       PE,
    input  logic                       CEP,
    input  logic                       CET,
    input  logic                       RELOAD_EN,
    output logic [STAGE_W*STAGES-1:0]  Q,
    output logic                       TC,
    output logic                       DONE,
    output logic [STAGE_W*STAGES-1:0]  RLD
);

    localparam int N = STAGE_W * STAGES;

    logic [STAGES-1:0][STAGE_W-1:0] stage_q;
    logic [STAGES:0]                cet_chain;
    logic                           zero_event;
    logic [N-1:0]                   reload_val;

    // A counted edge with the whole counter at zero replaces the borrow wrap.
    assign zero_event = CEP && CET && !PE && (Q == ZERO);
    assign reload_val = RELOAD_EN ? RLD : ALL_ONES;

    assign cet_chain[0] = CET;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        down_counter_stage #(
            .STAGE_W (STAGE_W)
        ) u_stage (
            .CP      (CP),
            .SR      (SR),
            .P       (P[k*STAGE_W +: STAGE_W]),
            .PE      (PE),
            .CEP     (CEP),
            .CET     (cet_chain[k]),
            .LD_ZERO (zero_event),
            .LD_VAL  (reload_val[k*STAGE_W +: STAGE_W]),
            .Q       (stage_q[k]),
            .TC      (cet_chain[k+1])
        );
    end

    assign Q  = stage_q;
    assign TC = cet_chain[STAGES];

    always_ff @(posedge CP) begin
        if (SR) begin
            RLD  <= '0;
            DONE <= 1'b0;
        end else begin
            if (PE) begin
                RLD <= P;
            end
            DONE <= zero_event;
        end
    end

endmodule

// File: tb/tb_down_counter_unit.sv
// Scoreboard bench for down_counter_unit: a behavioural model queues the
// expected post-edge state; a monitor pops and compares after each edge.
module tb_down_counter_unit;

    logic       CP = 1'b0;
    logic       SR = 1'b0;
    logic [7:0] P = '0;
    logic       PE = 1'b0;
    logic       CEP = 1'b0;
    logic       CET = 1'b0;
    logic       RELOAD_EN = 1'b0;
    logic [7:0] Q;
    logic       TC;
    logic       DONE;
    logic [7:0] RLD;

    down_counter_unit dut (
        .CP        (CP),
        .SR        (SR),
        .P         (P),
        .PE        (PE),
        .CEP       (CEP),
        .CET       (CET),
        .RELOAD_EN (RELOAD_EN),
        .Q         (Q),
        .TC        (TC),
        .DONE      (DONE),
        .RLD       (RLD)
    );

    always #5 CP = ~CP;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic [7:0] rld;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_q;
    logic [7:0] m_rld;
    logic       m_done;
    logic       m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check TC combinationally, queue the post-edge state.
    task automatic step(input logic sr, input logic pe, input logic [7:0] p,
                        input logic cep, input logic cet, input logic rel,
                        input string tag);
        exp_t e;
        @(negedge CP);
        SR = sr; PE = pe; P = p; CEP = cep; CET = cet; RELOAD_EN = rel;
        #1;
        if (m_valid) check({tag, ".tc"}, 32'(TC), 32'(cet && (m_q == 8'h00)));
        if (sr) begin
            m_q = 8'h00; m_rld = 8'h00; m_done = 1'b0;
        end else if (pe) begin
            m_q = p; m_rld = p; m_done = 1'b0;
        end else if (cep && cet) begin
            if (m_q == 8'h00) begin
                m_q    = rel ? m_rld : 8'hFF;
                m_done = 1'b1;
            end else begin
                m_q    = m_q - 8'h01;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
        m_valid = m_valid || sr;
        e.tag = tag; e.q = m_q; e.rld = m_rld; e.done = m_done;
        sb.push_back(e);
    endtask

    always @(posedge CP) begin
        if (sb.size() != 0) begin
            #1;
            mon_e = sb.pop_front();
            check({mon_e.tag, ".q"},    32'(Q),    32'(mon_e.q));
            check({mon_e.tag, ".rld"},  32'(RLD),  32'(mon_e.rld));
            check({mon_e.tag, ".done"}, 32'(DONE), 32'(mon_e.done));
        end
    end

    initial begin
        // Reset, then TC follows CET with Q at zero.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "reset");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "idle_tc");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "idle_cet0");

        // Reload enabled with RLD=0: Q stays 0, DONE on every counted edge.
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "rld0_a");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "rld0_b");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "rld0_hold");

        // Load 0x12 and count through the 0x10 -> 0x0F stage borrow to zero.
        step(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, "load_12");
        for (int i = 0; i < 18; i++)
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "count_12");

        // Reload from 0x05 at zero, then continue counting.
        step(1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, "load_05");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "count_05");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "reload_05");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "after_reload");

        // Count to zero, then wrap to all-ones without reload.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "count_04");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "wrap_ff");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "after_wrap");

        // Load beats count; CET=0 holds with TC low.
        step(1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, "load_30");
        step(1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0, "load_wins");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "hold_cet0");
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "hold_cep0");

        // Load zero: TC right after the load, next counted edge is a zero event.
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "load_00");
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "zero_after_load");

        // Reset wins over a pending zero event.
        step(1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, "load_09");
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "load_00b");
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "sr_wins");

        // Mixed random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 40)),
                 $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                 1'($urandom_range(0, 1)), "random");
        end

        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "drain");
        @(negedge CP);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
